tmds_multi_lane_encoder: RTL and testbench

//  - NUM_CH-lane HDMI/DVI symbol encoder: 8b/10b TMDS video, 2b control, TERC4 data island, guard bands.
//  - 2-stage pipeline, per-lane running-disparity counter, clock-enable gated.
//  - Sits between the timing/packet generator and the 10:1 serialisers, one 10-bit symbol per lane per enabled cycle.

---
 rtl/tmds_pkg.sv | 42 ++++
 rtl/tmds_lane_enc.sv | 119 +++++++++++
 rtl/tmds_multi_lane_encoder.sv | 62 ++++++
 tb/tb_tmds_multi_lane_encoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol tables, mode encodings and the stage-1 data record.
// Used by tmds_lane_enc and tmds_multi_lane_encoder.
package tmds_pkg;

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_ISLAND = 3'd2;
    localparam logic [2:0] MODE_VGUARD = 3'd3;
    localparam logic [2:0] MODE_DGUARD = 3'd4;

    // Indexed by {C1,C0}
    localparam logic [9:0] CTRL_CODE [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] TERC4_CODE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    typedef struct packed {
        logic       vid;
        logic [8:0] qm;
        logic [3:0] n1;
        logic [9:0] code;
    } s1_t;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: stage 1 transition-minimises or looks up the symbol, stage 2 DC-balances.
// Optional macro TMDS_DISP_MON_EN exposes the running disparity and a sticky overflow flag.
module tmds_lane_enc
    import tmds_pkg::*;
#(
    parameter int LANE   = 0,
    parameter int DISP_W = 6
) (
    input  logic                     clklow,
    input  logic                     reset,
    input  logic                     ce,
    input  logic [2:0]               mode,
    input  logic [7:0]               pix,
    input  logic [1:0]               ctl,
    input  logic [3:0]               aux,
    output logic [9:0]               q
`ifdef TMDS_DISP_MON_EN
    ,
    output logic signed [DISP_W-1:0] disp_cnt,
    output logic                     disp_err
`endif
);

    localparam logic signed [DISP_W-1:0] ZERO    = '0;
    localparam logic signed [DISP_W-1:0] TWO     = DISP_W'(2);
    localparam logic signed [DISP_W-1:0] EIGHT   = DISP_W'(8);

    logic [3:0]  n1_pix;
    logic        use_xnor;
    logic [8:0]  qm;
    logic [9:0]  code;
    s1_t         s1_p1;

    always_comb begin
        n1_pix   = popcount8(pix);
        use_xnor = (n1_pix > 4'd4) || ((n1_pix == 4'd4) && !pix[0]);
        qm       = '0;
        qm[0]    = pix[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ pix[i]) : (qm[i-1] ^ pix[i]);
        end
        qm[8]    = ~use_xnor;
    end

    always_comb begin
        case (mode)
            MODE_ISLAND: code = TERC4_CODE[aux];
            MODE_VGUARD: code = (LANE == 1) ? GUARD_B : GUARD_A;
            MODE_DGUARD: code = (LANE == 0) ? TERC4_CODE[{2'b11, ctl}] : GUARD_B;
            default:     code = CTRL_CODE[ctl];
        endcase
    end

    // ---- stage 1 -> stage 2 boundary ----
    always_ff @(posedge clklow) begin
        if (reset) begin
            s1_p1 <= '{vid: 1'b0, qm: 9'd0, n1: 4'd0, code: CTRL_CODE[0]};
        end else if (ce) begin
            s1_p1.vid  <= (mode == MODE_VIDEO);
            s1_p1.qm   <= qm;
            s1_p1.n1   <= popcount8(qm[7:0]);
            s1_p1.code <= code;
        end
    end

    logic signed [DISP_W-1:0] cnt_p2;
    logic signed [DISP_W-1:0] cnt_nxt;
    logic signed [DISP_W-1:0] n1_s;
    logic signed [DISP_W-1:0] diff;
    logic [9:0]               q_nxt;
    logic                     qm8;

    always_comb begin
        qm8  = s1_p1.qm[8];
        n1_s = $signed({{(DISP_W-4){1'b0}}, s1_p1.n1});
        diff = n1_s + n1_s - EIGHT;
        if (!s1_p1.vid) begin
            q_nxt   = s1_p1.code;
            cnt_nxt = ZERO;
        end else if ((cnt_p2 == ZERO) || (s1_p1.n1 == 4'd4)) begin
            q_nxt   = {~qm8, qm8, qm8 ? s1_p1.qm[7:0] : ~s1_p1.qm[7:0]};
            cnt_nxt = qm8 ? (cnt_p2 + diff) : (cnt_p2 - diff);
        end else if (((cnt_p2 > ZERO) && (s1_p1.n1 > 4'd4)) ||
                     ((cnt_p2 < ZERO) && (s1_p1.n1 < 4'd4))) begin
            q_nxt   = {1'b1, qm8, ~s1_p1.qm[7:0]};
            cnt_nxt = cnt_p2 - diff + (qm8 ? TWO : ZERO);
        end else begin
            q_nxt   = {1'b0, qm8, s1_p1.qm[7:0]};
            cnt_nxt = cnt_p2 + diff - (qm8 ? ZERO : TWO);
        end
    end

    // ---- stage 2 output register ----
    always_ff @(posedge clklow) begin
        if (reset) begin
            q      <= CTRL_CODE[0];
            cnt_p2 <= ZERO;
        end else if (ce) begin
            q      <= q_nxt;
            cnt_p2 <= cnt_nxt;
        end
    end

`ifdef TMDS_DISP_MON_EN
    localparam logic signed [DISP_W-1:0] LIM     = DISP_W'(10);
    localparam logic signed [DISP_W-1:0] NEG_LIM = DISP_W'(-10);

    always_ff @(posedge clklow) begin
        if (reset) begin
            disp_err <= 1'b0;
        end else if (ce && ((cnt_nxt > LIM) || (cnt_nxt < NEG_LIM))) begin
            disp_err <= 1'b1;
        end
    end

    assign disp_cnt = cnt_p2;
`endif

endmodule

// File: rtl/tmds_multi_lane_encoder.sv
// NUM_CH-lane TMDS/TERC4/guard-band symbol encoder with a 2-stage ce-gated pipeline.
// Optional macro TMDS_DISP_MON_EN adds disp_cnt/disp_err monitor outputs.
module tmds_multi_lane_encoder
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 6
) (
    input  logic                       clklow,
    input  logic                       reset,
    input  logic                       ce,
    input  logic [2:0]                 mode,
    input  logic [8*NUM_CH-1:0]        pix_data,
    input  logic [2*NUM_CH-1:0]        H_VSync_Ctr,
    input  logic [4*NUM_CH-1:0]        aux_data,
    output logic [10*NUM_CH-1:0]       q_out,
    output logic                       q_valid
`ifdef TMDS_DISP_MON_EN
    ,
    output logic [DISP_W*NUM_CH-1:0]   disp_cnt,
    output logic [NUM_CH-1:0]          disp_err
`endif
);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        tmds_lane_enc #(
            .LANE   (n),
            .DISP_W (DISP_W)
        ) u_lane (
            .clklow   (clklow),
            .reset    (reset),
            .ce       (ce),
            .mode     (mode),
            .pix      (pix_data[8*n +: 8]),
            .ctl      (H_VSync_Ctr[2*n +: 2]),
            .aux      (aux_data[4*n +: 4]),
            .q        (q_out[10*n +: 10])
`ifdef TMDS_DISP_MON_EN
            ,
            .disp_cnt (disp_cnt[DISP_W*n +: DISP_W]),
            .disp_err (disp_err[n])
`endif
        );
    end

    logic vld_p1;
    logic vld_p2;

    // ---- valid travels beside the lane stages ----
    always_ff @(posedge clklow) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (ce) begin
            vld_p1 <= ce;
            vld_p2 <= vld_p1;
        end
    end

    assign q_valid = vld_p2;

endmodule

// File: tb/tb_tmds_multi_lane_encoder.sv
// Self-checking bench: directed literal cases plus randomized stream against a behavioural model.
module tb_tmds_multi_lane_encoder;

    localparam int NUM_CH = 3;
    localparam int DISP_W = 6;

    localparam logic [2:0] M_CTRL = 3'd0, M_VID = 3'd1, M_ISL = 3'd2, M_VG = 3'd3, M_DG = 3'd4;

    localparam logic [9:0] CTRL_T [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    localparam logic [9:0] TERC4_T [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    logic                   clklow = 1'b0;
    logic                   reset;
    logic                   ce;
    logic [2:0]             mode;
    logic [8*NUM_CH-1:0]    pix_data;
    logic [2*NUM_CH-1:0]    H_VSync_Ctr;
    logic [4*NUM_CH-1:0]    aux_data;
    logic [10*NUM_CH-1:0]   q_out;
    logic                   q_valid;
`ifdef TMDS_DISP_MON_EN
    logic [DISP_W*NUM_CH-1:0] disp_cnt;
    logic [NUM_CH-1:0]        disp_err;
`endif

    tmds_multi_lane_encoder #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) dut (
        .clklow      (clklow),
        .reset       (reset),
        .ce          (ce),
        .mode        (mode),
        .pix_data    (pix_data),
        .H_VSync_Ctr (H_VSync_Ctr),
        .aux_data    (aux_data),
        .q_out       (q_out),
        .q_valid     (q_valid)
`ifdef TMDS_DISP_MON_EN
        ,
        .disp_cnt    (disp_cnt),
        .disp_err    (disp_err)
`endif
    );

    always #5 clklow = ~clklow;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Balance rules written directly from the symbol definition: choose chain by
    // pixel popcount, then invert/flag depending on disparity sign.
    function automatic bit [9:0] video_model(input bit [7:0] d, input int cin, output int cout);
        int  n1, ones, zeros;
        bit  xn, q8;
        bit [7:0] qm;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += d[i];
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        q8 = !xn;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += qm[i];
        zeros = 8 - ones;
        if (cin == 0 || ones == zeros) begin
            cout = q8 ? cin + ones - zeros : cin + zeros - ones;
            return {~q8, q8, q8 ? qm : ~qm};
        end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
            cout = cin + (q8 ? 2 : 0) + zeros - ones;
            return {1'b1, q8, ~qm};
        end else begin
            cout = cin - (q8 ? 0 : 2) + ones - zeros;
            return {1'b0, q8, qm};
        end
    endfunction

    bit [9:0] m_q [NUM_CH];
    bit [9:0] p_q [NUM_CH];
    int       m_cnt [NUM_CH];
    bit       m_v, p_v;

    always @(posedge clklow) begin
        if (reset) begin
            for (int l = 0; l < NUM_CH; l++) begin
                m_q[l] = CTRL_T[0];
                p_q[l] = CTRL_T[0];
                m_cnt[l] = 0;
            end
            m_v = 1'b0;
            p_v = 1'b0;
        end else if (ce) begin
            for (int l = 0; l < NUM_CH; l++) begin
                bit [7:0] pl;
                bit [1:0] cl;
                bit [3:0] al;
                int nc;
                pl = pix_data[8*l +: 8];
                cl = H_VSync_Ctr[2*l +: 2];
                al = aux_data[4*l +: 4];
                m_q[l] = p_q[l];
                if (mode == M_VID) begin
                    p_q[l] = video_model(pl, m_cnt[l], nc);
                    m_cnt[l] = nc;
                end else begin
                    m_cnt[l] = 0;
                    case (mode)
                        M_ISL:   p_q[l] = TERC4_T[al];
                        M_VG:    p_q[l] = (l == 1) ? 10'b0100110011 : 10'b1011001100;
                        M_DG:    p_q[l] = (l == 0) ? TERC4_T[{2'b11, cl}] : 10'b0100110011;
                        default: p_q[l] = CTRL_T[cl];
                    endcase
                end
            end
            m_v = p_v;
            p_v = 1'b1;
        end
    end

    always @(negedge clklow) begin
        if (cmp_en) begin
            for (int l = 0; l < NUM_CH; l++)
                chk($sformatf("q_out[%0d]", l), q_out[10*l +: 10], m_q[l]);
            chk("q_valid", {9'd0, q_valid}, {9'd0, m_v});
        end
    end

    task automatic send(input logic [2:0] m, input logic [7:0] px, input logic [1:0] c0,
                        input logic [3:0] ax, input logic e, input logic r);
        mode        = m;
        pix_data    = {NUM_CH{px}};
        H_VSync_Ctr = {{(NUM_CH-1){2'b00}}, c0};
        aux_data    = {NUM_CH{ax}};
        ce          = e;
        reset       = r;
        @(negedge clklow);
    endtask

    task automatic send_rand(input logic [2:0] m, input logic e, input logic r);
        logic [31:0] a, b;
        a = $urandom();
        b = $urandom();
        mode        = m;
        pix_data    = a[8*NUM_CH-1:0];
        H_VSync_Ctr = b[2*NUM_CH-1:0];
        aux_data    = b[16 +: 4*NUM_CH];
        ce          = e;
        reset       = r;
        @(negedge clklow);
    endtask

    task automatic lit_all(input string name, input logic [9:0] exp);
        for (int l = 0; l < NUM_CH; l++)
            chk($sformatf("%s[%0d]", name, l), q_out[10*l +: 10], exp);
    endtask

    initial begin
        int c;
        bit [9:0] v;
        v = video_model(8'h00, 0, c);
        chk("model 00/0", v, 10'h100);
        chk("model 00/0 cnt", 10'(c), 10'(-8));
        v = video_model(8'h00, -8, c);
        chk("model 00/-8", v, 10'h3FF);
        chk("model 00/-8 cnt", 10'(c), 10'd2);
        v = video_model(8'hFF, 0, c);
        chk("model FF/0", v, 10'h200);

        mode = M_CTRL; pix_data = '0; H_VSync_Ctr = '0; aux_data = '0;
        ce = 1'b0; reset = 1'b1;
        @(negedge clklow);
        cmp_en = 1'b1;
        send(M_CTRL, 8'h00, 2'b00, 4'h0, 1'b1, 1'b1);
        lit_all("reset q", 10'h354);
        chk("reset vld", {9'd0, q_valid}, 10'd0);

        send(M_CTRL, 8'h00, 2'b01, 4'h0, 1'b1, 1'b0);
        send(M_CTRL, 8'h00, 2'b01, 4'h0, 1'b1, 1'b0);
        chk("ctrl01 lane0", q_out[9:0], 10'h0AB);
        chk("ctrl01 vld", {9'd0, q_valid}, 10'd1);

        send(M_VID, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);
        send(M_VID, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);
        lit_all("vid00 a", 10'h100);
        send(M_CTRL, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);
        lit_all("vid00 b", 10'h3FF);
        send(M_CTRL, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);

        send(M_VID, 8'hFF, 2'b00, 4'h0, 1'b1, 1'b0);
        send(M_CTRL, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);
        lit_all("vidFF", 10'h200);
        send(M_CTRL, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);

        send(M_ISL, 8'h00, 2'b00, 4'h9, 1'b1, 1'b0);
        send(M_VID, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);
        lit_all("island9", 10'h139);
        send(M_CTRL, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);
        lit_all("vid after isl", 10'h100);

        send(M_VG, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);
        send(M_DG, 8'h00, 2'b10, 4'h0, 1'b1, 1'b0);
        chk("vguard l0", q_out[9:0], 10'h2CC);
        chk("vguard l1", q_out[19:10], 10'h133);
        chk("vguard l2", q_out[29:20], 10'h2CC);
        send(M_CTRL, 8'h00, 2'b00, 4'h0, 1'b1, 1'b0);
        chk("dguard l0", q_out[9:0], 10'h163);
        chk("dguard l1", q_out[19:10], 10'h133);

        for (int k = 0; k < 8; k++) begin
            send_rand(M_VID, 1'b1, 1'b0);
            send_rand(M_VID, 1'b0, 1'b0);
            send_rand(M_VID, 1'b0, 1'b0);
            send_rand(M_VID, 1'b1, 1'b0);
        end

        repeat (3) send_rand(M_VID, 1'b1, 1'b0);
        send_rand(M_VID, 1'b1, 1'b1);
        lit_all("midreset q", 10'h354);
        chk("midreset vld", {9'd0, q_valid}, 10'd0);

        for (int k = 0; k < 10000; k++) begin
            int r;
            logic [2:0] m;
            r = int'($urandom_range(0, 12));
            m = (r < 5) ? M_VID : 3'(r - 5);
            send_rand(m, ($urandom_range(0, 4) != 0), ($urandom_range(0, 999) == 0));
        end
        send_rand(M_CTRL, 1'b1, 1'b0);

`ifdef TMDS_DISP_MON_EN
        chk("disp_err", {7'd0, disp_err}, 10'd0);
`endif
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
